// File: rtl/press_classifier.sv
// Button press classifier: short, long and double press detection.
// Consumes a debounced level and emits one-cycle classification pulses.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = 1000,
  parameter int unsigned DBL_WINDOW  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic [7:0] press_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    HOLD,
    GAP,
    PRESS2
  } state_e;

  localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);
  localparam logic [15:0] DBL_LAST  = 16'(DBL_WINDOW - 1);

  state_e      state_q;
  logic [15:0] timer_q;
  logic        prev_q;
  logic        short_q;
  logic        long_q;
  logic        dbl_q;
  logic [7:0]  cnt_q;
  logic        rise;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign rise = btn_level & ~prev_q;

  // Classifier FSM; pulses and event count are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      prev_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= btn_level;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= PRESS1;
            timer_q <= '0;
          end
        end
        PRESS1: begin
          if (!btn_level) begin
            state_q <= GAP;
            timer_q <= '0;
          end else if (timer_q == LONG_LAST) begin
            long_q  <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
            state_q <= HOLD;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        HOLD: begin
          if (!btn_level) begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (rise) begin
            state_q <= PRESS2;
            timer_q <= '0;
          end else if (timer_q == DBL_LAST) begin
            short_q <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        PRESS2: begin
          if (!btn_level) begin
            dbl_q   <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
            state_q <= IDLE;
          end else if (timer_q == LONG_LAST) begin
            dbl_q   <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
            state_q <= HOLD;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = dbl_q;
  assign press_count  = cnt_q;
  assign busy         = (state_q != IDLE);

endmodule
